// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch front end: issues word fetches on a req/gnt/rvalid bus,
// buffers the returned words in a FIFO and hands them with their PC to the IF stage.
module instr_prefetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] BOOT_ADDR,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_ADDR,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_INSTR,
  output logic [31:0] OUT_PC,
  output logic        OUT_ERR,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, REQ, REQ_STALE, HALT} state_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  state_t          state_q;
  logic            req_q;
  logic [31:0]     addr_q;
  logic [31:0]     fetch_addr_q;
  logic [31:0]     out_pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   discard_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic            err_halt_q;
  logic [31:0]     data_mem [DEPTH];
  logic            err_mem  [DEPTH];

  logic            gnt_acc, rsp, drop, push, pop;
  logic            halt_nxt, credit_nxt;
  logic [CW-1:0]   out_nxt, cnt_nxt, disc_nxt;
  logic [31:0]     fetch_nxt;

  always_comb begin
    gnt_acc  = req_q & instr_gnt_i;
    rsp      = instr_rvalid_i & (outstanding_q != '0);
    drop     = rsp & (discard_q != '0);
    push     = rsp & ~drop & ~REDIRECT;
    pop      = OUT_VALID & OUT_READY & ~REDIRECT;
    out_nxt  = outstanding_q + CW'(gnt_acc) - CW'(rsp);
    cnt_nxt  = REDIRECT ? '0 : (count_q + CW'(push) - CW'(pop));
    // On redirect every request still in flight, including one granted now, is stale.
    disc_nxt = REDIRECT ? out_nxt
                        : (discard_q - CW'(drop) + CW'((state_q == REQ_STALE) && gnt_acc));
    halt_nxt   = ~REDIRECT & (err_halt_q | (push & instr_err_i));
    credit_nxt = (out_nxt < MAX_C) && ((cnt_nxt + out_nxt) < DEPTH_C);
    if (REDIRECT)
      fetch_nxt = align_word(REDIRECT_ADDR);
    else if ((state_q == REQ) && gnt_acc)
      fetch_nxt = fetch_addr_q + 32'd4;
    else
      fetch_nxt = fetch_addr_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!REDIRECT && halt_nxt) begin
            state_q <= HALT;
          end else if (!REDIRECT && credit_nxt) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (gnt_acc) begin
            if (REDIRECT) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end else if (halt_nxt) begin
              state_q <= HALT;
              req_q   <= 1'b0;
            end else if (!credit_nxt) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end else if (REDIRECT) begin
            state_q <= REQ_STALE;
          end
        end
        REQ_STALE: begin
          if (gnt_acc) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        HALT: begin
          if (REDIRECT) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      err_halt_q    <= 1'b0;
      fetch_addr_q  <= align_word(BOOT_ADDR);
      out_pc_q      <= align_word(BOOT_ADDR);
      addr_q        <= align_word(BOOT_ADDR);
    end else begin
      outstanding_q <= out_nxt;
      discard_q     <= disc_nxt;
      err_halt_q    <= halt_nxt;
      count_q       <= cnt_nxt;
      fetch_addr_q  <= fetch_nxt;
      // A request waiting for its grant keeps its address, even across a redirect.
      if (!(req_q && !instr_gnt_i)) addr_q <= fetch_nxt;
      if (REDIRECT) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        out_pc_q <= align_word(REDIRECT_ADDR);
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
          out_pc_q <= out_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem[wr_ptr_q] <= instr_rdata_i;
      err_mem[wr_ptr_q]  <= instr_err_i;
    end
  end

  assign OUT_VALID    = (count_q != '0);
  assign OUT_INSTR    = OUT_VALID ? data_mem[rd_ptr_q] : '0;
  assign OUT_ERR      = OUT_VALID & err_mem[rd_ptr_q];
  assign OUT_PC       = OUT_VALID ? out_pc_q : '0;
  assign instr_req_o  = req_q;
  assign instr_addr_o = addr_q;
  assign BUSY         = req_q | (outstanding_q != '0);

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Scoreboard bench for instr_prefetch_buffer: a bus responder answers each grant
// one cycle later and the expected IF-side stream is checked on every pop.
module tb_instr_prefetch_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] BOOT_ADDR;
  logic        REDIRECT;
  logic [31:0] REDIRECT_ADDR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_INSTR;
  logic [31:0] OUT_PC;
  logic        OUT_ERR;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        BUSY;

  always #5 CLK = ~CLK;

  instr_prefetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .CLK(CLK), .RST(RST), .BOOT_ADDR(BOOT_ADDR), .REDIRECT(REDIRECT),
    .REDIRECT_ADDR(REDIRECT_ADDR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_INSTR(OUT_INSTR), .OUT_PC(OUT_PC), .OUT_ERR(OUT_ERR),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .BUSY(BUSY)
  );

  typedef struct packed {logic [31:0] addr; logic stale;} rsp_t;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic err;} exp_t;

  rsp_t resp_q[$];
  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, n_gnt = 0, n_pop = 0, g0 = 0;
  int   first_req_cyc = -1, first_vld_cyc = -1;
  logic gnt_en = 1'b0, rsp_en = 1'b1;
  logic stale_pend = 1'b0, hold_prev = 1'b0, cap_arm = 1'b0, err_seen = 1'b0;
  logic [31:0] err_addr = 32'h1, exp_bus_addr = '0, stale_addr = '0, hold_addr = '0;
  logic [31:0] last_gnt_addr = '0, cap_pc = '0, err_pc = '0, a_old = '0;

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check_val("rst_req",   32'(instr_req_o), 32'h0);
    check_val("rst_valid", 32'(OUT_VALID),   32'h0);
    check_val("rst_instr", OUT_INSTR,        32'h0);
    check_val("rst_pc",    OUT_PC,           32'h0);
    check_val("rst_err",   32'(OUT_ERR),     32'h0);
    check_val("rst_busy",  32'(BUSY),        32'h0);
  endtask

  // One clock: drive the bus responder on the falling edge, book-keep what the
  // next rising edge will do, then return just after that rising edge.
  task automatic tick();
    logic granted, popped, responded;
    rsp_t r;
    exp_t e;
    @(negedge CLK);
    instr_gnt_i = gnt_en;
    if (!RST && rsp_en && resp_q.size() > 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = data_fn(resp_q[0].addr);
      instr_err_i    = (resp_q[0].addr == err_addr);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      instr_err_i    = 1'b0;
    end
    #1;
    cyc++;
    if (RST) begin
      resp_q.delete();
      exp_q.delete();
      exp_bus_addr = BOOT_ADDR & 32'hFFFF_FFFC;
      stale_pend   = 1'b0;
      hold_prev    = 1'b0;
    end else begin
      if (hold_prev) begin
        check_val("req_held",  32'(instr_req_o), 32'h1);
        check_val("addr_held", instr_addr_o, hold_addr);
      end
      hold_prev = instr_req_o & ~instr_gnt_i;
      hold_addr = instr_addr_o;
      granted   = instr_req_o & instr_gnt_i;
      popped    = OUT_VALID & OUT_READY & ~REDIRECT;
      responded = instr_rvalid_i;
      if (instr_req_o && first_req_cyc < 0) first_req_cyc = cyc;
      if (OUT_VALID && first_vld_cyc < 0) first_vld_cyc = cyc;

      if (popped) begin
        n_pop++;
        check_val("sb_has_entry", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_val("out_pc",    OUT_PC,        e.pc);
          check_val("out_instr", OUT_INSTR,     e.instr);
          check_val("out_err",   32'(OUT_ERR),  32'(e.err));
        end
        if (cap_arm) begin
          cap_pc  = OUT_PC;
          cap_arm = 1'b0;
        end
        if (OUT_ERR && !err_seen) begin
          err_seen = 1'b1;
          err_pc   = OUT_PC;
        end
      end

      if (granted) begin
        check_val("bus_addr", instr_addr_o, stale_pend ? stale_addr : exp_bus_addr);
        if (!stale_pend) exp_bus_addr = exp_bus_addr + 32'd4;
      end

      if (REDIRECT) begin
        if (instr_req_o && !instr_gnt_i && !stale_pend) begin
          stale_pend = 1'b1;
          stale_addr = exp_bus_addr;
        end
        exp_bus_addr = REDIRECT_ADDR & 32'hFFFF_FFFC;
        foreach (resp_q[i]) resp_q[i].stale = 1'b1;
        exp_q.delete();
      end

      if (responded) begin
        r = resp_q.pop_front();
        if (!r.stale) begin
          e.pc    = r.addr;
          e.instr = data_fn(r.addr);
          e.err   = (r.addr == err_addr);
          exp_q.push_back(e);
        end
      end

      if (granted) begin
        r.addr  = instr_addr_o;
        r.stale = REDIRECT | stale_pend;
        resp_q.push_back(r);
        if (stale_pend && !REDIRECT) stale_pend = 1'b0;
        n_gnt++;
        last_gnt_addr = instr_addr_o;
        check_val("outstanding_le2", 32'(resp_q.size() <= 2), 32'h1);
        check_val("credit_le_depth", 32'((resp_q.size() + exp_q.size()) <= 4), 32'h1);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; BOOT_ADDR = 32'h0000_0080; REDIRECT = 1'b0; REDIRECT_ADDR = '0;
    OUT_READY = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    instr_rdata_i = '0; instr_err_i = 1'b0;

    // Reset state
    repeat (2) tick();
    check_reset_outputs();

    // Sequential fetch from 0x80
    RST = 1'b0; gnt_en = 1'b1; OUT_READY = 1'b1;
    first_req_cyc = -1; first_vld_cyc = -1;
    repeat (20) tick();
    check_val("first_valid_latency", 32'(first_vld_cyc - first_req_cyc), 32'd2);
    check_val("seq_pop_count", 32'(n_pop >= 15), 32'h1);

    // Backpressure: FIFO fills to four words and requests stop
    OUT_READY = 1'b0;
    repeat (10) tick();
    check_val("bp_fifo_words", 32'(exp_q.size()), 32'd4);
    check_val("bp_outstanding", 32'(resp_q.size()), 32'd0);
    check_val("bp_req_idle", 32'(instr_req_o), 32'h0);
    check_val("bp_valid", 32'(OUT_VALID), 32'h1);
    g0 = n_gnt;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    repeat (6) tick();
    check_val("bp_one_req_per_pop", 32'(n_gnt - g0), 32'd1);
    check_val("bp_refilled", 32'(exp_q.size()), 32'd4);

    // Redirect with two responses outstanding and two words buffered
    rsp_en = 1'b0; OUT_READY = 1'b1;
    repeat (2) tick();
    OUT_READY = 1'b0;
    repeat (3) tick();
    check_val("rd_outstanding", 32'(resp_q.size()), 32'd2);
    check_val("rd_buffered", 32'(exp_q.size()), 32'd2);
    REDIRECT = 1'b1; REDIRECT_ADDR = 32'h0000_1002;
    tick();
    REDIRECT = 1'b0;
    check_val("rd_flushed", 32'(OUT_VALID), 32'h0);
    check_val("rd_busy", 32'(BUSY), 32'h1);
    cap_arm = 1'b1; rsp_en = 1'b1; OUT_READY = 1'b1;
    repeat (15) tick();
    check_val("rd_first_pc", cap_pc, 32'h0000_1000);
    check_val("rd_capture_done", 32'(cap_arm), 32'h0);

    // Redirect while a request waits for its grant
    gnt_en = 1'b0;
    repeat (3) tick();
    check_val("stall_req", 32'(instr_req_o), 32'h1);
    a_old = exp_bus_addr;
    REDIRECT = 1'b1; REDIRECT_ADDR = 32'h0000_2000;
    tick();
    REDIRECT = 1'b0; cap_arm = 1'b1;
    repeat (2) tick();
    check_val("stale_addr_held", instr_addr_o, a_old);
    gnt_en = 1'b1;
    repeat (15) tick();
    check_val("stale_first_pc", cap_pc, 32'h0000_2000);

    // Bus error on 0x88 halts fetching
    err_addr = 32'h0000_0088; err_seen = 1'b0;
    REDIRECT = 1'b1; REDIRECT_ADDR = 32'h0000_0080;
    tick();
    REDIRECT = 1'b0;
    repeat (14) tick();
    check_val("err_seen", 32'(err_seen), 32'h1);
    check_val("err_pc", err_pc, 32'h0000_0088);
    g0 = n_gnt;
    repeat (8) tick();
    check_val("halt_no_grants", 32'(n_gnt - g0), 32'd0);
    check_val("halt_req", 32'(instr_req_o), 32'h0);
    check_val("halt_busy", 32'(BUSY), 32'h0);
    err_addr = 32'h1;
    REDIRECT = 1'b1; REDIRECT_ADDR = 32'h0000_0300;
    tick();
    REDIRECT = 1'b0;
    g0 = n_gnt;
    repeat (6) tick();
    check_val("halt_exit", 32'(n_gnt > g0), 32'h1);

    // Mid-stream reset with a boot address that wraps
    BOOT_ADDR = 32'hFFFF_FFFC; RST = 1'b1;
    tick();
    check_reset_outputs();
    RST = 1'b0;
    g0 = n_gnt;
    repeat (3) tick();
    check_val("wrap_grants", 32'(n_gnt - g0), 32'd2);
    check_val("wrap_addr", last_gnt_addr, 32'h0000_0000);
    repeat (8) tick();
    check_val("wrap_pops", 32'(n_pop > 0), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
